// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-subset datapath: FETCH/DECODE/EXEC/MEM/WB FSM with internal register file and ALU.
// Optional macro MULTICYCLE_DATAPATH_BNE_EN adds bne (opcode 000101); without it that opcode halts as illegal.
module multicycle_datapath #(
    parameter int                N        = 32,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              instr_req,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic              instr_valid,
    input  logic [31:0]       instr_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [N-1:0]      mem_wdata,
    input  logic              mem_ready,
    input  logic [N-1:0]      mem_rdata,
    output logic              retire,
    output logic              halted,
    output logic              illegal,
    output logic [2:0]        dbg_state
);

    // Handshake: a request stays high with address/we/wdata stable until the cycle
    // valid/ready is sampled high on a rising edge; valid/ready without a request is ignored.
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
    } alu_op_t;

    state_t            state_q, state_d;
    logic              req_en;
    logic [ADDR_W-1:0] pc_q, pc4_q;
    logic [31:0]       ir_q;
    logic [N-1:0]      a_q, b_q, alu_q, mdr_q;
    logic              illegal_q;
    logic [N-1:0]      rf [32];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, wr_addr;
    logic [15:0] imm;
    alu_op_t     alu_op;
    logic        use_imm, zext, is_lw, is_sw, is_br, br_ne, wr_rd, legal, is_halt;
    logic [N-1:0]      imm_ext, opb, alu_y;
    logic [ADDR_W-1:0] imm_addr, br_target;
    logic              br_taken;

    assign opcode  = ir_q[31:26];
    assign rs      = ir_q[25:21];
    assign rt      = ir_q[20:16];
    assign rd      = ir_q[15:11];
    assign funct   = ir_q[5:0];
    assign imm     = ir_q[15:0];
    assign is_halt = (ir_q == 32'hFFFF_FFFF);

    always_comb begin
        alu_op  = ALU_ADD;
        use_imm = 1'b0;
        zext    = 1'b0;
        is_lw   = 1'b0;
        is_sw   = 1'b0;
        is_br   = 1'b0;
        br_ne   = 1'b0;
        wr_rd   = 1'b0;
        legal   = 1'b1;
        case (opcode)
            6'b000000: begin
                wr_rd = 1'b1;
                case (funct)
                    6'b100000: alu_op = ALU_ADD;
                    6'b100010: alu_op = ALU_SUB;
                    6'b100100: alu_op = ALU_AND;
                    6'b100101: alu_op = ALU_OR;
                    6'b101010: alu_op = ALU_SLT;
                    default:   legal  = 1'b0;
                endcase
            end
            6'b001000: use_imm = 1'b1;
            6'b001100: begin use_imm = 1'b1; zext = 1'b1; alu_op = ALU_AND; end
            6'b001101: begin use_imm = 1'b1; zext = 1'b1; alu_op = ALU_OR;  end
            6'b100011: begin use_imm = 1'b1; is_lw = 1'b1; end
            6'b101011: begin use_imm = 1'b1; is_sw = 1'b1; end
            6'b000100: is_br = 1'b1;
`ifdef MULTICYCLE_DATAPATH_BNE_EN
            6'b000101: begin is_br = 1'b1; br_ne = 1'b1; end
`endif
            default:   legal = 1'b0;
        endcase
    end

    assign imm_ext   = zext ? {{(N-16){1'b0}}, imm} : {{(N-16){imm[15]}}, imm};
    assign opb       = use_imm ? imm_ext : b_q;
    assign imm_addr  = {{(ADDR_W-16){imm[15]}}, imm};
    assign br_target = pc4_q + (imm_addr << 2);
    assign br_taken  = (a_q == b_q) ^ br_ne;
    assign wr_addr   = wr_rd ? rd : rt;

    always_comb begin
        alu_y = '0;
        case (alu_op)
            ALU_ADD: alu_y = a_q + opb;
            ALU_SUB: alu_y = a_q - opb;
            ALU_AND: alu_y = a_q & opb;
            ALU_OR:  alu_y = a_q | opb;
            ALU_SLT: alu_y = {{(N-1){1'b0}}, ($signed(a_q) < $signed(opb))};
            default: alu_y = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_FETCH;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (req_en && instr_valid) state_d = S_DECODE;
            S_DECODE: state_d = (is_halt || !legal) ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (is_br)              state_d = S_FETCH;
                else if (is_lw || is_sw) state_d = S_MEM;
                else                     state_d = S_WB;
            end
            S_MEM:    if (mem_ready) state_d = is_sw ? S_FETCH : S_WB;
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // req_en keeps instr_req low while reset is held, even though the state resets to FETCH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_en    <= 1'b0;
            pc_q      <= RESET_PC;
            pc4_q     <= '0;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_q     <= '0;
            mdr_q     <= '0;
            illegal_q <= 1'b0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            req_en <= 1'b1;
            case (state_q)
                S_FETCH: if (req_en && instr_valid) ir_q <= instr_data;
                S_DECODE: begin
                    a_q   <= rf[rs];
                    b_q   <= rf[rt];
                    pc4_q <= pc_q + ADDR_W'(4);
                    if (!is_halt && !legal) illegal_q <= 1'b1;
                end
                S_EXEC: begin
                    alu_q <= alu_y;
                    if (is_br) pc_q <= br_taken ? br_target : pc4_q;
                end
                S_MEM: if (mem_ready) begin
                    mdr_q <= mem_rdata;
                    if (is_sw) pc_q <= pc4_q;
                end
                S_WB: begin
                    if (wr_addr != 5'd0) rf[wr_addr] <= is_lw ? mdr_q : alu_q;
                    pc_q <= pc4_q;
                end
                default: ;
            endcase
        end
    end

    assign instr_req  = req_en && (state_q == S_FETCH);
    assign instr_addr = pc_q;
    assign mem_req    = (state_q == S_MEM);
    assign mem_we     = mem_req && is_sw;
    assign mem_addr   = ADDR_W'(alu_q);
    assign mem_wdata  = b_q;
    assign retire     = ((state_q == S_EXEC) && is_br) ||
                        ((state_q == S_MEM) && is_sw && mem_ready) ||
                        (state_q == S_WB);
    assign halted     = (state_q == S_HALT);
    assign illegal    = illegal_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: 32-bit core with wait-state memory models plus a 64-bit core.
module tb_multicycle_datapath;

    localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;
    localparam logic [5:0] OP_ADDI = 6'b001000, OP_ANDI = 6'b001100, OP_ORI = 6'b001101;
    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_BNE = 6'b000101;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
    localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;

    logic        ireq_a, mreq_a, mwe_a, retire_a, halted_a, illegal_a;
    logic        ivalid_a = 1'b0, mready_a = 1'b0;
    logic [31:0] iaddr_a, maddr_a, mwdata_a;
    logic [31:0] idata_a = '0, mrdata_a = '0;
    logic [2:0]  dbg_a;

    logic        ireq_b, mreq_b, mwe_b, retire_b, halted_b, illegal_b;
    logic        ivalid_b = 1'b0, mready_b = 1'b0;
    logic [31:0] iaddr_b, maddr_b;
    logic [63:0] mwdata_b;
    logic [31:0] idata_b = '0;
    logic [63:0] mrdata_b = '0;
    logic [2:0]  dbg_b;

    multicycle_datapath #(.N(32), .ADDR_W(32), .RESET_PC(32'h0)) dut_a (
        .clk(clk), .rst(rst_a),
        .instr_req(ireq_a), .instr_addr(iaddr_a), .instr_valid(ivalid_a), .instr_data(idata_a),
        .mem_req(mreq_a), .mem_we(mwe_a), .mem_addr(maddr_a), .mem_wdata(mwdata_a),
        .mem_ready(mready_a), .mem_rdata(mrdata_a),
        .retire(retire_a), .halted(halted_a), .illegal(illegal_a), .dbg_state(dbg_a)
    );

    multicycle_datapath #(.N(64), .ADDR_W(32), .RESET_PC(32'h0)) dut_b (
        .clk(clk), .rst(rst_b),
        .instr_req(ireq_b), .instr_addr(iaddr_b), .instr_valid(ivalid_b), .instr_data(idata_b),
        .mem_req(mreq_b), .mem_we(mwe_b), .mem_addr(maddr_b), .mem_wdata(mwdata_b),
        .mem_ready(mready_b), .mem_rdata(mrdata_b),
        .retire(retire_b), .halted(halted_b), .illegal(illegal_b), .dbg_state(dbg_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    // memory models: drive responses 1 time unit after each rising edge
    logic [31:0] imem_a [64];
    logic [31:0] dmem_a [64];
    logic [31:0] imem_b [64];
    int iwait_a = 0, dwait_a = 0, icnt_a = 0, dcnt_a = 0;

    always @(posedge clk) begin
        #1;
        if (ireq_a) begin
            ivalid_a = (icnt_a == iwait_a);
            idata_a  = imem_a[iaddr_a[7:2]];
            icnt_a++;
        end else begin
            ivalid_a = 1'b0;
            icnt_a   = 0;
        end
        if (mreq_a) begin
            mready_a = (dcnt_a == dwait_a);
            mrdata_a = dmem_a[maddr_a[7:2]];
            dcnt_a++;
        end else begin
            mready_a = 1'b0;
            dcnt_a   = 0;
        end
        ivalid_b = ireq_b;
        idata_b  = imem_b[iaddr_b[7:2]];
        mready_b = mreq_b;
    end

    // monitor + scoreboard for the 32-bit core
    logic [63:0] exp_q [$];
    logic [31:0] fetch_q [$];
    int          fetch_cyc_q [$];
    int          acc_len_q [$];
    logic [31:0] acc_addr_q [$];
    logic        we_q [$];
    int cyc = 0, first_req_cyc = -1, halt_cyc = -1, retire_cnt = 0, req_len = 0;

    always @(negedge clk) begin
        cyc++;
        if (ireq_a && first_req_cyc < 0) first_req_cyc = cyc;
        if (halted_a && halt_cyc < 0) halt_cyc = cyc;
        if (retire_a) retire_cnt++;
        if (ireq_a && ivalid_a) begin
            fetch_q.push_back(iaddr_a);
            fetch_cyc_q.push_back(cyc);
        end
        if (mreq_a) begin
            req_len++;
            if (mready_a) begin
                acc_len_q.push_back(req_len);
                acc_addr_q.push_back(maddr_a);
                we_q.push_back(mwe_a);
                req_len = 0;
                if (mwe_a) begin
                    dmem_a[maddr_a[7:2]] = mwdata_a;
                    check("store_pending", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        logic [63:0] e;
                        e = exp_q.pop_front();
                        check("store_addr", 64'(maddr_a), 64'(e[63:32]));
                        check("store_data", 64'(mwdata_a), 64'(e[31:0]));
                    end
                end
            end
        end
    end

    task automatic clear_mon();
        fetch_q.delete();
        fetch_cyc_q.delete();
        acc_len_q.delete();
        acc_addr_q.delete();
        we_q.delete();
        first_req_cyc = -1;
        halt_cyc      = -1;
        retire_cnt    = 0;
        req_len       = 0;
    endtask

    task automatic reset_a();
        rst_a = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 64; i++) imem_a[i] = HALT_W;
        clear_mon();
    endtask

    task automatic start_a();
        @(negedge clk);
        clear_mon();
        rst_a = 1'b1;
    endtask

    task automatic wait_halt_a(input string tag, input int max);
        int n = 0;
        while (!halted_a && n < max) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check(tag, 64'(halted_a), 64'd1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            imem_a[i] = HALT_W;
            imem_b[i] = HALT_W;
            dmem_a[i] = '0;
        end
        repeat (3) @(negedge clk);

        // reset values
        check("rst_instr_req", 64'(ireq_a), 64'd0);
        check("rst_mem_req", 64'(mreq_a), 64'd0);
        check("rst_mem_we", 64'(mwe_a), 64'd0);
        check("rst_retire", 64'(retire_a), 64'd0);
        check("rst_halted", 64'(halted_a), 64'd0);
        check("rst_illegal", 64'(illegal_a), 64'd0);
        check("rst_instr_addr", 64'(iaddr_a), 64'd0);
        check("rst_mem_addr", 64'(maddr_a), 64'd0);
        check("rst_mem_wdata", 64'(mwdata_a), 64'd0);

        // arithmetic program and halt timing, zero-wait
        reset_a();
        imem_a[0] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5);
        imem_a[1] = enc_i(OP_ADDI, 5'd0, 5'd2, 16'hFFFD);
        imem_a[2] = enc_r(5'd1, 5'd2, 5'd3, F_ADD);
        imem_a[3] = HALT_W;
        start_a();
        wait_halt_a("t1_halted", 100);
        check("t1_halt_latency", 64'(halt_cyc - first_req_cyc), 64'd14);
        check("t1_retires", 64'(retire_cnt), 64'd3);
        check("t1_illegal", 64'(illegal_a), 64'd0);
        check("t1_r1", 64'(dut_a.rf[1]), 64'd5);
        check("t1_r2", 64'(dut_a.rf[2]), 64'hFFFF_FFFD);
        check("t1_r3", 64'(dut_a.rf[3]), 64'd2);

        // store/load through a 3-wait data memory
        reset_a();
        dwait_a   = 3;
        dmem_a[0] = 32'hDEAD_BEEF;
        imem_a[0] = enc_i(OP_LW, 5'd0, 5'd1, 16'd0);
        imem_a[1] = enc_i(OP_SW, 5'd0, 5'd1, 16'd8);
        imem_a[2] = enc_i(OP_LW, 5'd0, 5'd4, 16'd8);
        imem_a[3] = enc_i(OP_SW, 5'd0, 5'd4, 16'd12);
        exp_q.push_back({32'd8, 32'hDEAD_BEEF});
        exp_q.push_back({32'd12, 32'hDEAD_BEEF});
        start_a();
        wait_halt_a("t2_halted", 200);
        check("t2_r4", 64'(dut_a.rf[4]), 64'hDEAD_BEEF);
        check("t2_stores_done", 64'(exp_q.size()), 64'd0);
        check("t2_accesses", 64'(acc_len_q.size()), 64'd4);
        if (acc_len_q.size() == 4) begin
            logic [31:0] exp_addr [4];
            logic        exp_we [4];
            exp_addr = '{32'd0, 32'd8, 32'd8, 32'd12};
            exp_we   = '{1'b0, 1'b1, 1'b0, 1'b1};
            for (int i = 0; i < 4; i++) begin
                check($sformatf("t2_req_len%0d", i), 64'(acc_len_q[i]), 64'd4);
                check($sformatf("t2_addr%0d", i), 64'(acc_addr_q[i]), 64'(exp_addr[i]));
                check($sformatf("t2_we%0d", i), 64'(we_q[i]), 64'(exp_we[i]));
            end
        end
        check("t2_fetches", 64'(fetch_cyc_q.size()), 64'd5);
        if (fetch_cyc_q.size() == 5) begin
            int exp_gap [4];
            exp_gap = '{8, 7, 8, 7};
            for (int i = 0; i < 4; i++)
                check($sformatf("t2_gap%0d", i), 64'(fetch_cyc_q[i+1] - fetch_cyc_q[i]), 64'(exp_gap[i]));
        end
        dwait_a = 0;

        // branches: not-taken, taken forward, taken to itself at 0x10
        reset_a();
        imem_a[0] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd1);
        imem_a[1] = enc_i(OP_BEQ, 5'd1, 5'd0, 16'd5);
        imem_a[2] = enc_i(OP_BEQ, 5'd0, 5'd0, 16'd1);
        imem_a[4] = enc_i(OP_BEQ, 5'd0, 5'd0, 16'hFFFF);
        start_a();
        begin
            int n = 0;
            while (fetch_q.size() < 6 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        check("t3_fetches", 64'(fetch_q.size() >= 6), 64'd1);
        if (fetch_q.size() >= 6) begin
            logic [31:0] exp_pc [6];
            int          exp_gap [5];
            exp_pc  = '{32'h0, 32'h4, 32'h8, 32'h10, 32'h10, 32'h10};
            exp_gap = '{4, 3, 3, 3, 3};
            for (int i = 0; i < 6; i++)
                check($sformatf("t3_pc%0d", i), 64'(fetch_q[i]), 64'(exp_pc[i]));
            for (int i = 0; i < 5; i++)
                check($sformatf("t3_gap%0d", i), 64'(fetch_cyc_q[i+1] - fetch_cyc_q[i]), 64'(exp_gap[i]));
        end
        check("t3_not_halted", 64'(halted_a), 64'd0);

        // opcode 000101
        reset_a();
        imem_a[0] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd7);
        imem_a[1] = enc_i(OP_BNE, 5'd1, 5'd0, 16'd2);
        imem_a[2] = enc_i(OP_ADDI, 5'd0, 5'd5, 16'd9);
        imem_a[4] = enc_i(OP_ADDI, 5'd0, 5'd6, 16'd3);
        start_a();
        wait_halt_a("t4_halted", 100);
        check("t4_r1", 64'(dut_a.rf[1]), 64'd7);
        check("t4_r5", 64'(dut_a.rf[5]), 64'd0);
`ifdef MULTICYCLE_DATAPATH_BNE_EN
        check("t4_illegal", 64'(illegal_a), 64'd0);
        check("t4_r6", 64'(dut_a.rf[6]), 64'd3);
        check("t4_retires", 64'(retire_cnt), 64'd3);
        check("t4_target", 64'(fetch_q.size() >= 3 ? fetch_q[2] : 32'hFFFF_FFFF), 64'h10);
`else
        check("t4_illegal", 64'(illegal_a), 64'd1);
        check("t4_r6", 64'(dut_a.rf[6]), 64'd0);
        check("t4_retires", 64'(retire_cnt), 64'd1);
`endif

        // reset asserted while a load is waiting on memory
        reset_a();
        dwait_a   = 20;
        dmem_a[0] = 32'h0000_1234;
        imem_a[0] = enc_i(OP_ADDI, 5'd0, 5'd4, 16'd5);
        imem_a[1] = enc_i(OP_LW, 5'd0, 5'd4, 16'd0);
        start_a();
        begin
            int n = 0;
            while (!mreq_a && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        check("t5_mem_req_seen", 64'(mreq_a), 64'd1);
        check("t5_r4_before", 64'(dut_a.rf[4]), 64'd5);
        repeat (2) @(negedge clk);
        #2 rst_a = 1'b0;
        #1;
        check("t5_mem_req_drop", 64'(mreq_a), 64'd0);
        check("t5_instr_req_drop", 64'(ireq_a), 64'd0);
        @(negedge clk);
        check("t5_r4_after", 64'(dut_a.rf[4]), 64'd0);
        dwait_a = 0;
        start_a();
        begin
            int n = 0;
            while (fetch_q.size() < 1 && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check("t5_refetch", 64'(fetch_q.size() >= 1 ? fetch_q[0] : 32'hFFFF_FFFF), 64'd0);
        rst_a = 1'b0;

        // 64-bit core
        imem_b[0] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'hFFFF);
        imem_b[1] = enc_r(5'd1, 5'd0, 5'd2, F_SLT);
        imem_b[2] = enc_i(OP_ANDI, 5'd1, 5'd3, 16'hFFFF);
        imem_b[3] = enc_i(OP_ORI, 5'd0, 5'd4, 16'h8000);
        imem_b[4] = enc_r(5'd0, 5'd4, 5'd5, F_SUB);
        imem_b[5] = enc_r(5'd1, 5'd4, 5'd6, F_AND);
        imem_b[6] = enc_r(5'd4, 5'd3, 5'd7, F_OR);
        imem_b[7] = enc_r(5'd0, 5'd1, 5'd8, F_SLT);
        imem_b[8] = enc_r(5'd1, 5'd1, 5'd0, F_ADD);
        @(negedge clk);
        rst_b = 1'b1;
        begin
            int n = 0;
            while (!halted_b && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        check("t6_halted", 64'(halted_b), 64'd1);
        check("t6_illegal", 64'(illegal_b), 64'd0);
        check("t6_r1", dut_b.rf[1], 64'hFFFF_FFFF_FFFF_FFFF);
        check("t6_r2", dut_b.rf[2], 64'd1);
        check("t6_r3", dut_b.rf[3], 64'h0000_0000_0000_FFFF);
        check("t6_r4", dut_b.rf[4], 64'h0000_0000_0000_8000);
        check("t6_r5", dut_b.rf[5], 64'hFFFF_FFFF_FFFF_8000);
        check("t6_r6", dut_b.rf[6], 64'h0000_0000_0000_8000);
        check("t6_r7", dut_b.rf[7], 64'h0000_0000_0000_FFFF);
        check("t6_r8", dut_b.rf[8], 64'd0);
        check("t6_r0", dut_b.rf[0], 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
